imem_loader: RTL and testbench

Byte-stream program loader that writes the write side of the 64 KB instruction memory, which the core fetches from combinationally. It receives a length-prefixed byte stream over a valid/ready handshake and assembles little-endian 32-bit words. Each word is written to consecutive word addresses starting at `BASE_ADDR`. The core is held in reset (`cpu_hold`) until a complete image has been written.

---
 rtl/imem_loader.sv | 132 +++++++++++++
 tb/tb_imem_loader.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Streams a length-prefixed little-endian byte image into instruction memory
// and holds the core in reset until the image has been fully written.
module imem_loader #(
    parameter int unsigned ADDR_W    = 14,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);
    localparam int unsigned CNT_W = 16;
    // Wide enough that BASE_ADDR + count and the 2^ADDR_W limit never overflow
    localparam int unsigned CHK_W = ((ADDR_W > CNT_W) ? ADDR_W : CNT_W) + 2;
    localparam logic [CHK_W-1:0] ADDR_LIMIT = CHK_W'(1) << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state;
    state_t             state_d;
    logic [7:0]         cnt_lo;
    logic [7:0]         cnt_lo_d;
    logic [CNT_W-1:0]   remaining;
    logic [CNT_W-1:0]   remaining_d;
    logic [1:0]         byte_idx;
    logic [1:0]         byte_idx_d;
    logic [ADDR_W-1:0]  waddr_d;
    logic [31:0]        wdata_d;
    logic [CNT_W-1:0]   count_c;
    logic [CHK_W-1:0]   end_addr_c;

    assign in_ready = (state == S_LEN0) || (state == S_LEN1) || (state == S_DATA);

    // Next-state and datapath update
    always_comb begin
        state_d     = state;
        cnt_lo_d    = cnt_lo;
        remaining_d = remaining;
        byte_idx_d  = byte_idx;
        waddr_d     = waddr;
        wdata_d     = wdata;
        count_c     = {in_data, cnt_lo};
        end_addr_c  = CHK_W'(BASE_ADDR) + CHK_W'(count_c);

        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_LEN0;
                    waddr_d = ADDR_W'(BASE_ADDR);
                end
            end
            S_LEN0: begin
                if (in_valid) begin
                    cnt_lo_d = in_data;
                    state_d  = S_LEN1;
                end
            end
            S_LEN1: begin
                if (in_valid) begin
                    if (count_c == '0) begin
                        state_d = S_DONE;
                    end else if (end_addr_c > ADDR_LIMIT) begin
                        state_d = S_ERR;
                    end else begin
                        state_d     = S_DATA;
                        byte_idx_d  = '0;
                        remaining_d = count_c;
                    end
                end
            end
            S_DATA: begin
                if (in_valid) begin
                    wdata_d[{byte_idx, 3'b000} +: 8] = in_data;
                    byte_idx_d = byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                waddr_d     = waddr + ADDR_W'(1);
                remaining_d = remaining - CNT_W'(1);
                state_d     = (remaining == CNT_W'(1)) ? S_DONE : S_DATA;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs; status flags follow the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt_lo    <= '0;
            remaining <= '0;
            byte_idx  <= '0;
            we        <= 1'b0;
            waddr     <= ADDR_W'(BASE_ADDR);
            wdata     <= '0;
            cpu_hold  <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_d;
            cnt_lo    <= cnt_lo_d;
            remaining <= remaining_d;
            byte_idx  <= byte_idx_d;
            we        <= (state_d == S_WRITE);
            waddr     <= waddr_d;
            wdata     <= wdata_d;
            cpu_hold  <= (state_d != S_DONE);
            done      <= (state_d == S_DONE);
            err       <= (state_d == S_ERR);
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: two instances (BASE_ADDR 0 and 1) share
// stimulus and are checked every cycle against a byte-position reference model.
module tb_imem_loader;
    localparam int unsigned AW = 14;

    typedef bit [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;

    logic          rdy0, we0, hold0, done0, err0;
    logic [AW-1:0] waddr0;
    logic [31:0]   wdata0;
    logic          rdy1, we1, hold1, done1, err1;
    logic [AW-1:0] waddr1;
    logic [31:0]   wdata1;

    imem_loader #(.ADDR_W(AW), .BASE_ADDR(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy0), .we(we0), .waddr(waddr0), .wdata(wdata0),
        .cpu_hold(hold0), .done(done0), .err(err0)
    );

    imem_loader #(.ADDR_W(AW), .BASE_ADDR(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy1), .we(we1), .waddr(waddr1), .wdata(wdata1),
        .cpu_hold(hold1), .done(done1), .err(err1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: tracks how many bytes of the current load were taken
    bit          m_active[2];
    bit          m_we[2];
    bit          m_done[2];
    bit          m_err[2];
    int          m_pos[2];
    int          m_left[2];
    bit [7:0]    m_lo[2];
    bit [AW-1:0] m_waddr[2];
    bit [31:0]   m_wdata[2];

    task automatic model_step(input int i);
        int b;
        int n;
        int lane;
        b = i;
        if (rst) begin
            m_active[i] = 0; m_we[i] = 0; m_done[i] = 0; m_err[i] = 0;
            m_pos[i] = 0; m_left[i] = 0; m_lo[i] = 8'h00;
            m_waddr[i] = AW'(b); m_wdata[i] = 32'h0;
        end else if (m_we[i]) begin
            m_we[i] = 0;
            m_waddr[i] = m_waddr[i] + AW'(1);
            m_left[i] = m_left[i] - 1;
            if (m_left[i] == 0) begin
                m_active[i] = 0;
                m_done[i] = 1;
            end
        end else if (!m_active[i]) begin
            if (start) begin
                m_active[i] = 1; m_pos[i] = 0; m_done[i] = 0; m_err[i] = 0;
                m_waddr[i] = AW'(b);
            end
        end else if (in_valid) begin
            if (m_pos[i] == 0) begin
                m_lo[i] = in_data;
            end else if (m_pos[i] == 1) begin
                n = int'(in_data) * 256 + int'(m_lo[i]);
                if (n == 0) begin
                    m_active[i] = 0; m_done[i] = 1;
                end else if (b + n > (1 << AW)) begin
                    m_active[i] = 0; m_err[i] = 1;
                end else begin
                    m_left[i] = n;
                end
            end else begin
                lane = (m_pos[i] - 2) % 4;
                m_wdata[i][8*lane +: 8] = in_data;
                if (lane == 3) m_we[i] = 1;
            end
            m_pos[i] = m_pos[i] + 1;
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
        cyc <= cyc + 1;
    end

    task automatic cmp_inst(input int i, input logic r, input logic w, input logic [AW-1:0] a,
                            input logic [31:0] d, input logic h, input logic dn, input logic e);
        chk($sformatf("in_ready[%0d]", i), 64'(r), 64'(m_active[i] && !m_we[i]));
        chk($sformatf("we[%0d]", i), 64'(w), 64'(m_we[i]));
        chk($sformatf("waddr[%0d]", i), 64'(a), 64'(m_waddr[i]));
        chk($sformatf("wdata[%0d]", i), 64'(d), 64'(m_wdata[i]));
        chk($sformatf("cpu_hold[%0d]", i), 64'(h), 64'(!m_done[i]));
        chk($sformatf("done[%0d]", i), 64'(dn), 64'(m_done[i]));
        chk($sformatf("err[%0d]", i), 64'(e), 64'(m_err[i]));
    endtask

    always @(negedge clk) begin
        if (cyc > 0) begin
            cmp_inst(0, rdy0, we0, waddr0, wdata0, hold0, done0, err0);
            cmp_inst(1, rdy1, we1, waddr1, wdata1, hold1, done1, err1);
        end
    end

    // Write log of instance 0 and event bookkeeping for the literal checks
    logic [AW-1:0] log_a[$];
    logic [31:0]   log_d[$];
    int            log_c[$];
    int            we1_cnt = 0;
    int            done_rise = -1;
    logic          done0_prev = 1'b0;

    always @(negedge clk) begin
        if (cyc > 0) begin
            if (we0 === 1'b1) begin
                log_a.push_back(waddr0);
                log_d.push_back(wdata0);
                log_c.push_back(cyc);
            end
            if (we1 === 1'b1) we1_cnt++;
            if (done0 === 1'b1 && done0_prev !== 1'b1) done_rise = cyc;
            done0_prev = done0;
        end
    end

    task automatic clear_log();
        log_a.delete();
        log_d.delete();
        log_c.delete();
        we1_cnt = 0;
        done_rise = -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_range(input bq_t q, input int lo, input int hi, input int pct);
        int i;
        int guard;
        logic acc;
        i = lo;
        guard = 0;
        while (i < hi && guard < 5000) begin
            @(negedge clk);
            in_valid = ($urandom_range(99) < pct);
            in_data  = in_valid ? q[i] : 8'($urandom);
            acc = in_valid && rdy0;
            @(posedge clk);
            if (acc) i++;
            guard++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        if (guard >= 5000) chk("send_timeout", 64'(i), 64'(hi));
    endtask

    task automatic wait_done();
        for (int k = 0; k < 300 && done0 !== 1'b1; k++) @(negedge clk);
        chk("wait_done", 64'(done0), 64'd1);
    endtask

    task automatic build_img(input bit [31:0] words[$], output bq_t img);
        img.delete();
        img.push_back(8'(words.size()));
        img.push_back(8'(words.size() >> 8));
        foreach (words[k]) begin
            for (int j = 0; j < 4; j++) img.push_back(words[k][8*j +: 8]);
        end
    endtask

    initial begin
        bq_t img;
        bq_t lenq;
        bit [31:0] words[$];

        // Reset and idle
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("idle_hold", 64'(hold0), 64'd1);
        chk("idle_ready", 64'(rdy0), 64'd0);
        chk("idle_we", 64'(we0), 64'd0);
        chk("idle_done", 64'(done0), 64'd0);

        // Two-word image, valid held high
        img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        clear_log();
        pulse_start();
        send_range(img, 0, img.size(), 100);
        wait_done();
        repeat (2) @(negedge clk);
        #1;
        chk("img1_nwrites", 64'(log_a.size()), 64'd2);
        if (log_a.size() == 2) begin
            chk("img1_a0", 64'(log_a[0]), 64'd0);
            chk("img1_d0", 64'(log_d[0]), 64'h00000013);
            chk("img1_a1", 64'(log_a[1]), 64'd1);
            chk("img1_d1", 64'(log_d[1]), 64'h00100093);
            chk("img1_gap", 64'(log_c[1] - log_c[0]), 64'd5);
            chk("img1_done_lat", 64'(done_rise), 64'(log_c[1] + 1));
        end
        chk("img1_hold", 64'(hold0), 64'd0);

        // Restart from DONE, 50% valid, stray start during DATA
        clear_log();
        pulse_start();
        chk("restart_hold", 64'(hold0), 64'd1);
        chk("restart_done", 64'(done0), 64'd0);
        send_range(img, 0, 5, 50);
        pulse_start();
        send_range(img, 5, img.size(), 50);
        wait_done();
        repeat (2) @(negedge clk);
        #1;
        chk("img2_nwrites", 64'(log_a.size()), 64'd2);
        if (log_a.size() == 2) begin
            chk("img2_d0", 64'(log_d[0]), 64'h00000013);
            chk("img2_d1", 64'(log_d[1]), 64'h00100093);
            chk("img2_a1", 64'(log_a[1]), 64'd1);
        end

        // 16384 words: too many for BASE_ADDR 1, exactly fits BASE_ADDR 0
        do_reset();
        clear_log();
        lenq = '{8'h00, 8'h40};
        pulse_start();
        send_range(lenq, 0, 2, 100);
        chk("len_err1", 64'(err1), 64'd1);
        chk("len_err_hold1", 64'(hold1), 64'd1);
        chk("len_ok_err0", 64'(err0), 64'd0);
        repeat (3) @(negedge clk);
        chk("len_err_no_we", 64'(we1_cnt), 64'd0);

        // Zero-length image
        do_reset();
        clear_log();
        lenq = '{8'h00, 8'h00};
        pulse_start();
        send_range(lenq, 0, 2, 100);
        chk("zero_done", 64'(done0), 64'd1);
        chk("zero_done1", 64'(done1), 64'd1);
        repeat (2) @(negedge clk);
        #1;
        chk("zero_nwrites", 64'(log_a.size() + we1_cnt), 64'd0);

        // Reset in the middle of a three-word load
        words = '{32'h11223344, 32'hA5A5F00D, 32'hDEADBEEF};
        build_img(words, img);
        clear_log();
        pulse_start();
        send_range(img, 0, 8, 100);
        do_reset();
        #1;
        chk("midrst_hold", 64'(hold0), 64'd1);
        chk("midrst_done", 64'(done0), 64'd0);
        chk("midrst_ready", 64'(rdy0), 64'd0);
        chk("midrst_nwrites", 64'(log_a.size()), 64'd1);
        if (log_a.size() == 1) chk("midrst_a0", 64'(log_a[0]), 64'd0);
        clear_log();
        pulse_start();
        send_range(img, 0, img.size(), 70);
        wait_done();
        repeat (2) @(negedge clk);
        #1;
        chk("reload_nwrites", 64'(log_a.size()), 64'd3);
        if (log_a.size() == 3) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("reload_a%0d", k), 64'(log_a[k]), 64'(k));
                chk($sformatf("reload_d%0d", k), 64'(log_d[k]), 64'(words[k]));
            end
        end

        // Random images with random stalls
        for (int t = 0; t < 6; t++) begin
            int n;
            int pct;
            n = int'($urandom_range(1, 6));
            pct = int'($urandom_range(30, 100));
            words.delete();
            for (int k = 0; k < n; k++) words.push_back($urandom);
            build_img(words, img);
            clear_log();
            pulse_start();
            send_range(img, 0, img.size(), pct);
            wait_done();
            repeat (2) @(negedge clk);
            #1;
            chk($sformatf("rand%0d_nwrites", t), 64'(log_a.size()), 64'(n));
            if (log_a.size() == n) begin
                for (int k = 0; k < n; k++) begin
                    chk($sformatf("rand%0d_a%0d", t, k), 64'(log_a[k]), 64'(k));
                    chk($sformatf("rand%0d_d%0d", t, k), 64'(log_d[k]), 64'(words[k]));
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
